regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 169 ++++++++++++++++
 tb/tb_regfile_sb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: register file with a load scoreboard.
//
// Purpose: 2**D registers of W bits with two combinational read ports, an
// ALU write port (0) and a load-return write port (1). A busy bit per register
// tracks outstanding loads. ALU writes to busy registers are dropped. Issuing
// a load to a register that is already busy is rejected. A load return to a
// register that is not busy is still written. Each of these three cases sets
// the sticky err flag. Register PROT_REG is a read-only all-ones constant.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   branch_en                  port A reads CMP_REG instead of r_addr_a
//   r_addr_a/b, data_out_a/b   read addresses / read data
//   busy_a/b, stall            busy bit of each effective read address, OR of both
//   we0/waddr0/wdata0          ALU write port
//   we1/waddr1/wdata1          load-return write port
//   issue_en/issue_addr        load issue (sets busy)
//   pend_cnt                   outstanding load count (popcount of busy)
//   err                        sticky hazard-violation flag
//
// Configuration: define REGFILE_BYPASS_EN to forward same-cycle write data
// (and cleared busy) to the read ports.
module regfile_sb #(
    parameter int W        = 8,
    parameter int D        = 3,
    parameter int CMP_REG  = 7,
    parameter int PROT_REG = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         branch_en,
    input  logic [D-1:0] r_addr_a,
    input  logic [D-1:0] r_addr_b,
    output logic [W-1:0] data_out_a,
    output logic [W-1:0] data_out_b,
    output logic         busy_a,
    output logic         busy_b,
    output logic         stall,
    input  logic         we0,
    input  logic [D-1:0] waddr0,
    input  logic [W-1:0] wdata0,
    input  logic         we1,
    input  logic [D-1:0] waddr1,
    input  logic [W-1:0] wdata1,
    input  logic         issue_en,
    input  logic [D-1:0] issue_addr,
    output logic [D:0]   pend_cnt,
    output logic         err
);

    localparam int DEPTH = 1 << D;
    localparam logic [D-1:0] PROT_A = D'(PROT_REG);
    localparam logic [D-1:0] CMP_A  = D'(CMP_REG);

    // Number of set bits in the busy vector.
    function automatic logic [D:0] popcount(input logic [DEPTH-1:0] v);
        logic [D:0] c;
        c = {(D+1){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{D{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [W-1:0]     regs_q [DEPTH];
    logic [W-1:0]     regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [D:0]       pend_q, pend_d;
    logic             err_q, err_d;

    logic [D-1:0] ea_s;
    logic         w0_acc_s, w1_acc_s, collide_s, clr_issue_s, issue_ok_s;
    logic         w0_haz_s, w1_spur_s, issue_haz_s;

    // Write acceptance, scoreboard decisions and hazard detection.
    always_comb begin
        ea_s        = branch_en ? CMP_A : r_addr_a;
        // Both write ports on one address: port 1 wins and neither flags err.
        collide_s   = we0 && we1 && (waddr0 == waddr1);
        w1_acc_s    = we1 && (waddr1 != PROT_A);
        w0_acc_s    = we0 && (waddr0 != PROT_A) && !busy_q[waddr0] && !collide_s;
        w0_haz_s    = we0 && (waddr0 != PROT_A) && busy_q[waddr0] && !collide_s;
        w1_spur_s   = w1_acc_s && !busy_q[waddr1] && !collide_s;
        // A load returning this cycle frees the slot for a new issue.
        clr_issue_s = w1_acc_s && (waddr1 == issue_addr);
        issue_ok_s  = issue_en && (issue_addr != PROT_A)
                      && (!busy_q[issue_addr] || clr_issue_s);
        issue_haz_s = issue_en && (issue_addr != PROT_A)
                      && busy_q[issue_addr] && !clr_issue_s;
    end

    // Next-state for registers, busy vector, pending count and err.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (w0_acc_s) begin
            regs_d[waddr0] = wdata0;
        end else begin
            regs_d[waddr0] = regs_q[waddr0];
        end
        if (w1_acc_s) begin
            regs_d[waddr1] = wdata1;
            busy_d[waddr1] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        // Issue is applied after the clear so a new load supersedes a return.
        if (issue_ok_s) begin
            busy_d[issue_addr] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        pend_d = popcount(busy_d);
        err_d  = err_q | w0_haz_s | w1_spur_s | issue_haz_s;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i == PROT_REG) ? {W{1'b1}} : {W{1'b0}};
            end
            busy_q <= {DEPTH{1'b0}};
            pend_q <= {(D+1){1'b0}};
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    // Combinational read ports, optionally bypassing same-cycle writes.
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        if (w1_acc_s && (waddr1 == ea_s)) begin
            data_out_a = wdata1;
            busy_a     = 1'b0;
        end else if (w0_acc_s && (waddr0 == ea_s)) begin
            data_out_a = wdata0;
            busy_a     = busy_q[ea_s];
        end else begin
            data_out_a = regs_q[ea_s];
            busy_a     = busy_q[ea_s];
        end
        if (w1_acc_s && (waddr1 == r_addr_b)) begin
            data_out_b = wdata1;
            busy_b     = 1'b0;
        end else if (w0_acc_s && (waddr0 == r_addr_b)) begin
            data_out_b = wdata0;
            busy_b     = busy_q[r_addr_b];
        end else begin
            data_out_b = regs_q[r_addr_b];
            busy_b     = busy_q[r_addr_b];
        end
`else
        data_out_a = regs_q[ea_s];
        busy_a     = busy_q[ea_s];
        data_out_b = regs_q[r_addr_b];
        busy_b     = busy_q[r_addr_b];
`endif
        stall = busy_a | busy_b;
    end

    assign pend_cnt = pend_q;
    assign err      = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       branch_en = 1'b0;
    logic [2:0] r_addr_a = 3'd0, r_addr_b = 3'd0;
    logic [7:0] data_out_a, data_out_b;
    logic       busy_a, busy_b, stall;
    logic       we0 = 1'b0, we1 = 1'b0, issue_en = 1'b0;
    logic [2:0] waddr0 = 3'd0, waddr1 = 3'd0, issue_addr = 3'd0;
    logic [7:0] wdata0 = 8'd0, wdata1 = 8'd0;
    logic [3:0] pend_cnt;
    logic       err;

    int errors = 0;
    int checks = 0;

    regfile_sb dut (
        .clk(clk), .reset(reset), .branch_en(branch_en),
        .r_addr_a(r_addr_a), .r_addr_b(r_addr_b),
        .data_out_a(data_out_a), .data_out_b(data_out_b),
        .busy_a(busy_a), .busy_b(busy_b), .stall(stall),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .pend_cnt(pend_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge, then settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; issue_en = 1'b0; branch_en = 1'b0;
    endtask

    initial begin
        // Reset held: address 0 is the protected all-ones register.
        #12;
        chk("rst_dout_a", {24'd0, data_out_a}, 32'hFF);
        chk("rst_dout_b", {24'd0, data_out_b}, 32'hFF);
        chk("rst_busy_stall", {29'd0, busy_a, busy_b, stall}, 32'd0);
        chk("rst_pend", {28'd0, pend_cnt}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            r_addr_a = 3'(i);
            #1;
            chk($sformatf("read_reg%0d", i), {24'd0, data_out_a}, (i == 0) ? 32'hFF : 32'h00);
        end

        // Load flow on register 3.
        issue_en = 1'b1; issue_addr = 3'd3; r_addr_b = 3'd3;
        tick();
        idle();
        #1;
        chk("load_busy_b", {31'd0, busy_b}, 32'd1);
        chk("load_stall", {31'd0, stall}, 32'd1);
        chk("load_pend1", {28'd0, pend_cnt}, 32'd1);
        we1 = 1'b1; waddr1 = 3'd3; wdata1 = 8'h5A;
        tick();
        idle();
        #1;
        chk("load_data", {24'd0, data_out_b}, 32'h5A);
        chk("load_busy_clr", {31'd0, busy_b}, 32'd0);
        chk("load_pend0", {28'd0, pend_cnt}, 32'd0);
        chk("load_err0", {31'd0, err}, 32'd0);

        // Simultaneous writes to register 4, then a write to the protected register.
        we0 = 1'b1; waddr0 = 3'd4; wdata0 = 8'h22;
        we1 = 1'b1; waddr1 = 3'd4; wdata1 = 8'h33;
        tick();
        idle();
        r_addr_a = 3'd4;
        #1;
        chk("sim_port1_wins", {24'd0, data_out_a}, 32'h33);
        chk("sim_no_err", {31'd0, err}, 32'd0);
        we0 = 1'b1; waddr0 = 3'd0; wdata0 = 8'h00;
        tick();
        idle();
        r_addr_a = 3'd0;
        #1;
        chk("prot_hold", {24'd0, data_out_a}, 32'hFF);

        // Issue to the protected register is ignored.
        issue_en = 1'b1; issue_addr = 3'd0;
        tick();
        idle();
        #1;
        chk("prot_issue_pend", {28'd0, pend_cnt}, 32'd0);
        chk("prot_issue_err", {31'd0, err}, 32'd0);

        // Branch reads the compare register.
        we0 = 1'b1; waddr0 = 3'd7; wdata0 = 8'h80;
        tick();
        idle();
        branch_en = 1'b1; r_addr_a = 3'd1;
        #1;
        chk("branch_data", {24'd0, data_out_a}, 32'h80);
        issue_en = 1'b1; issue_addr = 3'd7;
        tick();
        issue_en = 1'b0;
        #1;
        chk("branch_busy", {31'd0, busy_a}, 32'd1);
        we1 = 1'b1; waddr1 = 3'd7; wdata1 = 8'h81;
        tick();
        idle();
        branch_en = 1'b1;
        #1;
        chk("branch_ret_data", {24'd0, data_out_a}, 32'h81);
        chk("branch_ret_pend", {28'd0, pend_cnt}, 32'd0);
        branch_en = 1'b0;

        // Bypass: visible in the write cycle only when enabled.
        we0 = 1'b1; waddr0 = 3'd5; wdata0 = 8'h44; r_addr_a = 3'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_same", {24'd0, data_out_a}, 32'h44);
`else
        chk("bypass_same", {24'd0, data_out_a}, 32'h00);
`endif
        tick();
        idle();
        #1;
        chk("bypass_next", {24'd0, data_out_a}, 32'h44);
        chk("no_err_yet", {31'd0, err}, 32'd0);

        // Hazard: ALU write to a busy register is dropped and sets err.
        issue_en = 1'b1; issue_addr = 3'd2;
        tick();
        idle();
        we0 = 1'b1; waddr0 = 3'd2; wdata0 = 8'h11;
        tick();
        idle();
        r_addr_a = 3'd2;
        #1;
        chk("haz_unchanged", {24'd0, data_out_a}, 32'h00);
        chk("haz_err", {31'd0, err}, 32'd1);
        tick(); tick();
        chk("haz_err_sticky", {31'd0, err}, 32'd1);
        // Double issue: rejected, count unchanged.
        issue_en = 1'b1; issue_addr = 3'd2;
        tick();
        idle();
        #1;
        chk("dbl_issue_pend", {28'd0, pend_cnt}, 32'd1);
        // Issue and return on the same register: data stored, still busy.
        issue_en = 1'b1; issue_addr = 3'd2;
        we1 = 1'b1; waddr1 = 3'd2; wdata1 = 8'h77;
        tick();
        idle();
        #1;
        chk("supersede_data", {24'd0, data_out_a}, 32'h77);
        chk("supersede_busy", {31'd0, busy_a}, 32'd1);
        chk("supersede_pend", {28'd0, pend_cnt}, 32'd1);

        // Mid-operation reset discards pending loads and err.
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_pend", {28'd0, pend_cnt}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        chk("mid_rst_data", {24'd0, data_out_a}, 32'h00);
        #3;
        reset = 1'b1;
        tick();
        // Return after reset to a non-busy register: spurious.
        we1 = 1'b1; waddr1 = 3'd2; wdata1 = 8'h99;
        tick();
        idle();
        #1;
        chk("spur_data", {24'd0, data_out_a}, 32'h99);
        chk("spur_err", {31'd0, err}, 32'd1);
        chk("spur_pend", {28'd0, pend_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
